// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA 640x480@60 timing constants, widths, payload types and
// helpers. Imported by the controller, the counter sub-module and any image
// generator so that all of them agree on frame geometry and colour width.
package vga_pkg;

    // Horizontal timing, in pixel clocks
    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    // Vertical timing, in lines
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Visible frame geometry shared with the image generator
    localparam int unsigned FRAME_WIDTH  = 640;
    localparam int unsigned FRAME_HEIGHT = 480;

    localparam int unsigned COLOR_W     = 3;
    localparam int unsigned CNT_W       = 12;
    localparam int unsigned FRAME_CNT_W = 16;

    // First and last counter value whose following cycle drives sync low
    localparam int unsigned H_SYNC_FIRST = H_VISIBLE + H_FP;
    localparam int unsigned H_SYNC_LAST  = H_VISIBLE + H_FP + H_SYNC - 1;
    localparam int unsigned V_SYNC_FIRST = V_VISIBLE + V_FP;
    localparam int unsigned V_SYNC_LAST  = V_VISIBLE + V_FP + V_SYNC - 1;

    typedef logic [CNT_W-1:0]       coord_t;
    typedef logic [COLOR_W-1:0]     color_t;
    typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

    // Registered pin stage towards the DAC / connector
    typedef struct packed {
        color_t rgb;
        logic   hsync;
        logic   vsync;
    } vga_pins_t;

    // Inclusive range test on a counter value
    function automatic logic in_range(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_if.sv
// vga_if: bundle between the VGA controller and its image generator / pins.
//   master : controller side (drives timing, pins, frame_cnt; reads color)
//   slave  : generator / observer side (drives color; reads everything else)
interface vga_if
    import vga_pkg::*;
();
    color_t     color;
    coord_t     x;
    coord_t     y;
    logic       active;
    logic       frame_start;
    color_t     vga_rgb;
    logic       vga_hsync;
    logic       vga_vsync;
    frame_cnt_t frame_cnt;

    modport master (
        input  color,
        output x, y, active, frame_start,
        output vga_rgb, vga_hsync, vga_vsync, frame_cnt
    );

    modport slave (
        output color,
        input  x, y, active, frame_start,
        input  vga_rgb, vga_hsync, vga_vsync, frame_cnt
    );
endinterface

// File: rtl/vga_sync_counter.sv
// vga_sync_counter: owns the x/y raster counters and their wrap rules.
//   CLOCK_25  pixel clock
//   RESET_N   async active-low reset
//   x, y      registered counters
//   x_next_c  value x takes at the next edge (combinational)
//   y_next_c  value y takes at the next edge (combinational)
module vga_sync_counter
    import vga_pkg::*;
(
    input  logic   CLOCK_25,
    input  logic   RESET_N,
    output coord_t x,
    output coord_t y,
    output coord_t x_next_c,
    output coord_t y_next_c
);

    coord_t x_q;
    coord_t y_q;
    logic   x_wrap_c;

    // Out-of-range values (>= total) are treated as a wrap point
    always_comb begin
        x_wrap_c = (x_q >= CNT_W'(H_TOTAL - 1));
        x_next_c = x_wrap_c ? '0 : x_q + CNT_W'(1);
        y_next_c = y_q;
        if (y_q >= CNT_W'(V_TOTAL)) begin
            y_next_c = '0;
        end else if (x_wrap_c) begin
            y_next_c = (y_q == CNT_W'(V_TOTAL - 1)) ? '0 : y_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_next_c;
            y_q <= y_next_c;
        end
    end

    assign x = x_q;
    assign y = y_q;

endmodule

// File: rtl/vga_controller.sv
// vga_controller: 640x480@60 VGA timing generator with registered pin stage.
//   CLOCK_25  25 MHz pixel clock
//   RESET_N   async active-low reset
//   bus       vga_if.master: color in; x, y, active, frame_start, vga_rgb,
//             vga_hsync, vga_vsync, frame_cnt out
// Optional feature: define VGA_FRAME_COUNT_EN to count completed frames on
// frame_cnt; otherwise frame_cnt is tied to zero.
module vga_controller
    import vga_pkg::*;
(
    input  logic CLOCK_25,
    input  logic RESET_N,
    vga_if.master bus
);

    coord_t    x;
    coord_t    y;
    coord_t    x_next_c;
    coord_t    y_next_c;
    logic      active_q;
    logic      frame_start_q;
    vga_pins_t pins_q;

    vga_sync_counter u_sync (
        .CLOCK_25 (CLOCK_25),
        .RESET_N  (RESET_N),
        .x        (x),
        .y        (y),
        .x_next_c (x_next_c),
        .y_next_c (y_next_c)
    );

    // active/frame_start decode the next x/y so they line up with the current
    // registered x/y; pins decode the current x/y so they lag by one cycle.
    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
            pins_q        <= '{rgb: '0, hsync: 1'b1, vsync: 1'b1};
        end else begin
            active_q      <= (x_next_c < CNT_W'(FRAME_WIDTH)) &&
                             (y_next_c < CNT_W'(FRAME_HEIGHT));
            frame_start_q <= (x_next_c == '0) && (y_next_c == '0);
            pins_q.rgb    <= active_q ? bus.color : '0;
            pins_q.hsync  <= !in_range(x, CNT_W'(H_SYNC_FIRST), CNT_W'(H_SYNC_LAST));
            pins_q.vsync  <= !in_range(y, CNT_W'(V_SYNC_FIRST), CNT_W'(V_SYNC_LAST));
        end
    end

    assign bus.x           = x;
    assign bus.y           = y;
    assign bus.active      = active_q;
    assign bus.frame_start = frame_start_q;
    assign bus.vga_rgb     = pins_q.rgb;
    assign bus.vga_hsync   = pins_q.hsync;
    assign bus.vga_vsync   = pins_q.vsync;

`ifdef VGA_FRAME_COUNT_EN
    frame_cnt_t frame_cnt_q;
    logic       frame_wrap_c;

    // A frame completes on the edge where y wraps back to line 0
    assign frame_wrap_c = (x >= CNT_W'(H_TOTAL - 1)) && (y == CNT_W'(V_TOTAL - 1));

    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            frame_cnt_q <= '0;
        end else if (frame_wrap_c) begin
            frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    assign bus.frame_cnt = frame_cnt_q;
`else
    assign bus.frame_cnt = '0;
`endif

endmodule
